// File: rtl/clkdiv_pkg.sv
// clkdiv_multi shared constants and ratio helpers.
// Ratios are handled at MAX_W bits and cast to DIV_W at use.
package clkdiv_pkg;

    localparam int DIV_W_DEF       = 16;
    localparam int DEFAULT_DIV_DEF = 2;
    localparam int MAX_W           = 32;

    function automatic logic [MAX_W-1:0] hi_len(
        input logic [MAX_W-1:0] d
    );
        return d - (d >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] div_sanitize(
        input logic [MAX_W-1:0] d
    );
        return (d == '0) ? MAX_W'(1) : d;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, active/pending ratio,
// registered divided clock and period-start tick.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    output logic             pend,
    output logic             clk_o,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_pend;
    logic [DIV_W-1:0] div_nxt;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] hi;
    logic             wrap;

    always_comb begin
        wrap    = (cnt == div_act - DIV_W'(1)) || sync;
        div_nxt = pend ? div_pend : div_act;
        cnt_inc = cnt + DIV_W'(1);
        hi      = DIV_W'(hi_len(MAX_W'(div_act)));
    end

    // A write is only accepted while pend is clear, so it never
    // collides with a pending ratio being applied on this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= DIV_W'(DEFAULT_DIV - 1);
            div_act  <= DIV_W'(DEFAULT_DIV);
            div_pend <= DIV_W'(DEFAULT_DIV);
            pend     <= 1'b0;
            clk_o    <= 1'b0;
            tick_o   <= 1'b0;
        end else begin
            if (en) begin
                if (wrap) begin
                    cnt     <= '0;
                    div_act <= div_nxt;
                    pend    <= 1'b0;
                    clk_o   <= 1'b1;
                    tick_o  <= 1'b1;
                end else begin
                    cnt    <= cnt_inc;
                    clk_o  <= (cnt_inc < hi);
                    tick_o <= 1'b0;
                end
            end else begin
                cnt     <= div_nxt - DIV_W'(1);
                div_act <= div_nxt;
                pend    <= 1'b0;
                clk_o   <= 1'b0;
                tick_o  <= 1'b0;
            end
            if (wr) begin
                div_pend <= wr_div;
                pend     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider: cfg decode,
// ready mux and sync fan-out around NUM_CH channels.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int DIV_W       = DIV_W_DEF,
    parameter  int DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] clk_o,
    output logic [NUM_CH-1:0] tick_o
);

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] wr;
    logic [DIV_W-1:0]  wr_div;

    assign wr_div = DIV_W'(div_sanitize(MAX_W'(cfg_div)));

    // Out-of-range channels match nothing: ready stays high
    // and the write falls on the floor.
    always_comb begin
        cfg_ready = 1'b1;
        wr        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pend[i];
                wr[i]     = cfg_valid && !pend[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clkdiv_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (ch_en[g]),
            .sync   (sync),
            .wr     (wr[g]),
            .wr_div (wr_div),
            .pend   (pend[g]),
            .clk_o  (clk_o[g]),
            .tick_o (tick_o[g])
        );
    end

endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
- Parametrised successor to the fixed power-of-two ripple divider.
- Provides NUM_CH independent channels, each with a runtime-programmable integer ratio (any value ≥1, not only powers of two) and a per-channel enable.
- Each channel drives a registered divided clock and a one-cycle tick (clock-enable) pulse.
- Supports glitch-free ratio changes at period boundaries and a global phase-align strobe; sits next to the system clock source and feeds enables to slow peripherals.

Parameters:
NUM_CH, 4, number of divider channels (1..16)
DIV_W, 16, width of ratio and counter
DEFAULT_DIV, 2, ratio loaded into every channel at reset (1..2^DIV_W-1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
ch_en  in  NUM_CH  per-channel run enable
sync  in  1  single-cycle strobe: restart all enabled channels phase-aligned
cfg_valid  in  1  ratio write request
cfg_ready  out  1  write accepted when cfg_valid && cfg_ready
cfg_ch  in  max(1,$clog2(NUM_CH))  target channel
cfg_div  in  DIV_W  new ratio; 0 is stored as 1
clk_o  out  NUM_CH  divided clocks, registered
tick_o  out  NUM_CH  one-cycle pulse on the first cycle of each period, registered

Behaviour:
- Per-channel state: cnt[DIV_W], div_act[DIV_W], div_pend[DIV_W], pend (1 bit). hi_len = div_act - floor(div_act/2).
- Reset (rst_n=0 at an edge; priority over everything):
  - div_act = DEFAULT_DIV, cnt = DEFAULT_DIV-1, pend = 0.
  - clk_o = 0, tick_o = 0.
- Enabled edge (ch_en[i]=1):
  - cnt_n = (cnt == div_act-1) ? 0 : cnt+1.
  - clk_o <= (cnt_n < hi_len); tick_o <= (cnt_n == 0).
  - At the wrap, if pend=1: div_act <= div_pend, pend <= 0, and counting restarts against the new ratio.
- Resulting waveforms:
  - First enabled edge after reset or re-enable produces tick_o=1, clk_o=1; no extra latency.
  - div=1: clk_o and tick_o held 1 continuously.
  - Odd div: high for (div+1)/2 cycles, low for (div-1)/2.
  - Even div: exact 50% duty.
- Disabled edge (ch_en[i]=0):
  - clk_o <= 0, tick_o <= 0.
  - A pending ratio is applied immediately; cnt <= div_act_new-1, so re-enable starts a fresh period.
- sync=1 at an edge:
  - Every enabled channel: cnt <= 0, tick_o <= 1, clk_o <= 1, pending ratios applied.
  - Disabled channels: unaffected.
  - sync coinciding with a natural wrap behaves identically to the wrap.
- Config handshake:
  - cfg_ready = !pend[cfg_ch] (combinational from cfg_ch); cfg_ch ≥ NUM_CH gives cfg_ready=1 and the write is discarded.
  - Accepted write sets div_pend and pend from the next cycle. A write accepted in the same cycle as a wrap is NOT applied at that wrap; it waits for the next boundary.
- Arithmetic: counters are unsigned DIV_W bits; cnt never exceeds div_act-1, so there is no overflow.
- Mid-operation reset: all channels return to the reset state at that edge; pending writes are lost.

Decomposition:
- Package clkdiv_pkg holds:
  - the default DIV_W/DEFAULT_DIV constants;
  - a function computing hi_len;
  - a function sanitising a ratio (0→1).
- One sub-module, clkdiv_channel: a single channel (cnt, div_act, div_pend, pend, outputs), instantiated NUM_CH times by a generate loop.
- The top level holds only the cfg decode, cfg_ready mux and sync fan-out.

Test Plan:
1. Reset then ch_en=4'b0001, default div 2 -> clk_o[0] toggles 1,0,1,0 starting on the first edge after rst_n rises; tick_o[0] high every 2nd cycle.
2. Write ch1 div=5 while disabled, enable -> clk_o[1] pattern 1,1,1,0,0 repeating; tick_o[1] every 5 cycles; cfg_ready stays 1.
3. ch0 running div=4, write div=3 at cnt=1 -> remaining period completes with 4 cycles, then 3-cycle periods (1,1,0); cfg_ready[ch0] low from the accept until the wrap; a second write during that window is stalled.
4. ch0 div=3, ch1 div=7 both running, pulse sync -> both tick_o=1 and clk_o=1 on the next edge; subsequent ticks at +3 and +7 cycles.
5. Write div=0 to ch2 -> behaves as div=1: clk_o[2] and tick_o[2] held 1 while enabled, 0 when disabled.
6. Assert rst_n=0 for one edge mid-period with a write pending -> all outputs 0, ratios back to DEFAULT_DIV, pending write discarded; restart as in scenario 1.
